dram_bank_responder: RTL
========================

// Module: dram_bank_responder
// PURPOSE
// - Device-side end of the controller command interface: accepts cmd_req/cmd with one-hot bank/row/col selects, answers cmd_ack.
// - Holds per-bank open-row state and the storage array; exchanges one DATA_WIDTH word per READ/WRITE over the serial data line.
// - Serves as bring-up target and bench model for dram_ctrl; its top level owns the dram_data tristate pad.
// PARAMETERS
// - DATA_WIDTH    8    bits per word, serialised MSB first
// - NUM_OF_BANKS  8    banks; bank_sel width
// - NUM_OF_ROWS   128  rows per bank; row_sel width
// - NUM_OF_COLS   8    words per row; col_sel width
// - T_RCD / T_RP / T_CAS / T_RFC  3 / 2 / 2 / 8   wait cycles for ACTIVATE / PRECHARGE / READ latency / REFRESH (each >=1)
// PORTS
// - clk               in   1             clock; all logic on rising edge
// - rst               in   1             reset, asynchronous, active-high
// - cmd_req           in   1             command valid; held high until cmd_ack seen
// - cmd               in   2             00 PRECHARGE, 01 ACTIVATE, 10 READ/WRITE, 11 REFRESH
// - bank_rw           in   1             for cmd=10: 1 WRITE, 0 READ
// - bank_sel          in   NUM_OF_BANKS  one-hot bank
// - row_sel           in   NUM_OF_ROWS   one-hot row (ACTIVATE only)
// - col_sel           in   NUM_OF_COLS   one-hot column (READ/WRITE only)
// - dram_data_in      in   1             serial write data from controller
// - dram_data_out     out  1             serial read data
// - dram_data_oe      out  1             1 = responder drives the data line
// - cmd_ack           out  1             one-cycle completion pulse
// - cmd_err           out  1             valid with cmd_ack; 1 = command rejected, no state change
// - open_bank_mask    out  NUM_OF_BANKS  bit b = bank b has an open row
// BEHAVIOUR
// - Reset: all outputs 0, FSM IDLE, every bank closed. Array is not cleared (reads before writes return undefined data).
// - FSM: IDLE -> CHECK -> {ACT_WAIT|PRE_WAIT|REF_WAIT|RD_LAT|WR_SHIFT|ACK}. RD_LAT -> RD_SHIFT -> ACK. ACK -> REL -> IDLE.
// - IDLE: cmd_req=1 latches cmd, bank_rw, and all selects (one-hot encoded to binary). Next cycle is CHECK.
// - CHECK error conditions (go straight to ACK, cmd_err=1):
//   - any select used by the cmd is not exactly one-hot;
//   - ACTIVATE to an open bank;
//   - READ/WRITE or PRECHARGE to a closed bank;
//   - REFRESH while any bank is open.
// - ACTIVATE: T_RCD cycles, then bank row register <- row and mask bit set. PRECHARGE: T_RP cycles, mask bit cleared. REFRESH: T_RFC cycles.
// - READ:
//   - row = the bank's open row; row_sel is ignored.
//   - T_CAS cycles, then DATA_WIDTH cycles with oe=1, MSB first, one bit per cycle.
//   - oe drops at ACK.
// - WRITE:
//   - dram_data_in is sampled on the DATA_WIDTH edges following CHECK, MSB first.
//   - The word is committed to the array on the last sample edge; ACK follows.
// - ACK: cmd_ack=1 for exactly one cycle.
// - REL: wait for cmd_req=0 (four-phase handshake); a new command is accepted only from IDLE.
// - Latency from accept edge to ack = 2 + T_x, or 2 + T_CAS + DATA_WIDTH for READ, or 2 + DATA_WIDTH for WRITE.
// - cmd/select changes while busy are ignored (latched copy used).
// - Timer and bit counters are $clog2(max+1) bits; they never wrap.
// - rst mid-command: immediate abort, oe=0 asynchronously, a partial WRITE is not committed, all banks closed.
// STRUCTURE
// - Shared package dram_pkg: cmd encodings (CMD_PRE, CMD_ACT, CMD_RW, CMD_REF), FSM state enum, default timing constants.
// - One sub-module, dram_onehot_enc #(N): one-hot -> $clog2(N) index plus a valid flag (exactly one bit set). Instantiated for bank, row, col.
// - Storage: NUM_OF_BANKS*NUM_OF_ROWS*NUM_OF_COLS x DATA_WIDTH register array.
// TESTING
// - Reset with cmd_req=0: ack/err/oe/data_out=0, open_bank_mask=8'h00.
// - ACTIVATE bank 2, row 5: ack 5 cycles after accept, err=0, mask=8'h04. Repeat ACTIVATE bank 2: ack with err=1, mask unchanged.
// - WRITE 8'hA5 at bank 2, col 3, then READ the same location: oe high 8 cycles and serial bits 1,0,1,0,0,1,0,1; READ ack 12 cycles after accept.
// - READ bank 6 (closed): ack 2 cycles after accept with err=1, oe stays 0. bank_sel=8'h03: err=1.
// - REFRESH with bank 2 open: err=1. PRECHARGE bank 2, then REFRESH: mask=0, ack after 10 cycles with err=0.
// - rst asserted 4 bits into a WRITE of 8'hFF over 8'h00: oe=0 and mask=0 at once. Re-ACTIVATE and READ returns 8'h00. cmd_req held high after ack: no second ack.

Source files
------------

// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM bank responder: command codes, FSM states
// and default timing.
package dram_pkg;

    typedef enum logic [1:0] {
        CMD_PRE = 2'b00,
        CMD_ACT = 2'b01,
        CMD_RW  = 2'b10,
        CMD_REF = 2'b11
    } cmd_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ACT_WAIT,
        ST_PRE_WAIT,
        ST_REF_WAIT,
        ST_RD_LAT,
        ST_RD_SHIFT,
        ST_WR_SHIFT,
        ST_ACK,
        ST_REL
    } state_e;

    localparam int DEF_T_RCD = 3;
    localparam int DEF_T_RP  = 2;
    localparam int DEF_T_CAS = 2;
    localparam int DEF_T_RFC = 8;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/dram_bank_responder_if.sv
// Controller <-> responder command/data bundle; master is the controller side.
interface dram_bank_responder_if #(
    parameter int NUM_OF_BANKS = 8,
    parameter int NUM_OF_ROWS  = 128,
    parameter int NUM_OF_COLS  = 8
);
    logic                    cmd_req;
    logic [1:0]              cmd;
    logic                    bank_rw;
    logic [NUM_OF_BANKS-1:0] bank_sel;
    logic [NUM_OF_ROWS-1:0]  row_sel;
    logic [NUM_OF_COLS-1:0]  col_sel;
    logic                    dram_data_in;
    logic                    dram_data_out;
    logic                    dram_data_oe;
    logic                    cmd_ack;
    logic                    cmd_err;
    logic [NUM_OF_BANKS-1:0] open_bank_mask;

    modport master (
        output cmd_req, cmd, bank_rw, bank_sel, row_sel, col_sel, dram_data_in,
        input  dram_data_out, dram_data_oe, cmd_ack, cmd_err, open_bank_mask
    );

    modport slave (
        input  cmd_req, cmd, bank_rw, bank_sel, row_sel, col_sel, dram_data_in,
        output dram_data_out, dram_data_oe, cmd_ack, cmd_err, open_bank_mask
    );
endinterface

// File: rtl/dram_onehot_enc.sv
// One-hot to binary index; valid only when exactly one bit is set.
module dram_onehot_enc #(
    parameter int N = 8
) (
    input  logic [N-1:0]         onehot,
    output logic [$clog2(N)-1:0] idx,
    output logic                 valid
);
    localparam int W = $clog2(N);

    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++)
            if (onehot[i]) idx = idx | W'(i);
    end

    assign valid = (onehot != '0) && ((onehot & (onehot - 1'b1)) == '0);
endmodule

// File: rtl/dram_bank_responder.sv
// Device-side DRAM command responder: per-bank open-row tracking, storage
// array and serial word transfer over a single data line.
module dram_bank_responder
    import dram_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_OF_BANKS = 8,
    parameter int NUM_OF_ROWS  = 128,
    parameter int NUM_OF_COLS  = 8,
    parameter int T_RCD        = DEF_T_RCD,
    parameter int T_RP         = DEF_T_RP,
    parameter int T_CAS        = DEF_T_CAS,
    parameter int T_RFC        = DEF_T_RFC
) (
    input logic                  clk,
    input logic                  rst,
    dram_bank_responder_if.slave bus
);
    localparam int BW    = $clog2(NUM_OF_BANKS);
    localparam int RW    = $clog2(NUM_OF_ROWS);
    localparam int CW    = $clog2(NUM_OF_COLS);
    localparam int AW    = BW + RW + CW;
    localparam int DEPTH = NUM_OF_BANKS * NUM_OF_ROWS * NUM_OF_COLS;
    localparam int TW    = $clog2(max4(T_RCD, T_RP, T_CAS, T_RFC) + 1);
    localparam int NW    = $clog2(DATA_WIDTH + 1);

    logic [BW-1:0] bank_idx;
    logic [RW-1:0] row_idx;
    logic [CW-1:0] col_idx;
    logic          bank_ok, row_ok, col_ok;

    dram_onehot_enc #(.N(NUM_OF_BANKS)) u_bank_enc (.onehot(bus.bank_sel), .idx(bank_idx), .valid(bank_ok));
    dram_onehot_enc #(.N(NUM_OF_ROWS))  u_row_enc  (.onehot(bus.row_sel),  .idx(row_idx),  .valid(row_ok));
    dram_onehot_enc #(.N(NUM_OF_COLS))  u_col_enc  (.onehot(bus.col_sel),  .idx(col_idx),  .valid(col_ok));

    state_e                  state;
    cmd_e                    cmd_q;
    logic                    rw_q;
    logic [BW-1:0]           bank_q;
    logic [RW-1:0]           row_q;
    logic [CW-1:0]           col_q;
    logic                    bank_ok_q, row_ok_q, col_ok_q;
    logic                    err_q;
    logic [TW-1:0]           timer;
    logic [NW-1:0]           bit_cnt;
    logic [DATA_WIDTH-1:0]   sh;
    logic [RW-1:0]           open_row [NUM_OF_BANKS];
    logic [NUM_OF_BANKS-1:0] open_mask;
    logic                    ack_q, err_out, oe_q, dout_q;
    logic                    chk_err;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [AW-1:0]           addr;
    logic [DATA_WIDTH-1:0]   rd_word, wr_word;
    logic                    wr_commit;

    // READ/WRITE always address the row currently open in the latched bank
    assign addr      = {bank_q, open_row[bank_q], col_q};
    assign rd_word   = mem[addr];
    assign wr_word   = {sh[DATA_WIDTH-2:0], bus.dram_data_in};
    assign wr_commit = (state == ST_WR_SHIFT) && (bit_cnt == NW'(DATA_WIDTH - 1));

    always_comb begin
        chk_err = 1'b0;
        case (cmd_q)
            CMD_PRE: chk_err = !bank_ok_q || !open_mask[bank_q];
            CMD_ACT: chk_err = !bank_ok_q || !row_ok_q || open_mask[bank_q];
            CMD_RW:  chk_err = !bank_ok_q || !col_ok_q || !open_mask[bank_q];
            default: chk_err = |open_mask;
        endcase
    end

    // Storage is intentionally not reset; reset only blocks the commit via state
    always_ff @(posedge clk)
        if (wr_commit) mem[addr] <= wr_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cmd_q     <= CMD_PRE;
            rw_q      <= 1'b0;
            bank_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            bank_ok_q <= 1'b0;
            row_ok_q  <= 1'b0;
            col_ok_q  <= 1'b0;
            err_q     <= 1'b0;
            timer     <= '0;
            bit_cnt   <= '0;
            sh        <= '0;
            open_mask <= '0;
            for (int i = 0; i < NUM_OF_BANKS; i++) open_row[i] <= '0;
            ack_q     <= 1'b0;
            err_out   <= 1'b0;
            oe_q      <= 1'b0;
            dout_q    <= 1'b0;
        end else begin
            ack_q   <= 1'b0;
            err_out <= 1'b0;
            case (state)
                ST_IDLE: if (bus.cmd_req) begin
                    cmd_q     <= cmd_e'(bus.cmd);
                    rw_q      <= bus.bank_rw;
                    bank_q    <= bank_idx;
                    row_q     <= row_idx;
                    col_q     <= col_idx;
                    bank_ok_q <= bank_ok;
                    row_ok_q  <= row_ok;
                    col_ok_q  <= col_ok;
                    state     <= ST_CHECK;
                end
                ST_CHECK: begin
                    err_q <= chk_err;
                    if (chk_err) state <= ST_ACK;
                    else case (cmd_q)
                        CMD_ACT: begin timer <= TW'(T_RCD - 1); state <= ST_ACT_WAIT; end
                        CMD_PRE: begin timer <= TW'(T_RP - 1);  state <= ST_PRE_WAIT; end
                        CMD_REF: begin timer <= TW'(T_RFC - 1); state <= ST_REF_WAIT; end
                        default: if (rw_q) begin
                            bit_cnt <= '0;
                            state   <= ST_WR_SHIFT;
                        end else begin
                            timer <= TW'(T_CAS - 1);
                            state <= ST_RD_LAT;
                        end
                    endcase
                end
                ST_ACT_WAIT: if (timer == '0) begin
                    open_row[bank_q]  <= row_q;
                    open_mask[bank_q] <= 1'b1;
                    state             <= ST_ACK;
                end else timer <= timer - 1'b1;
                ST_PRE_WAIT: if (timer == '0) begin
                    open_mask[bank_q] <= 1'b0;
                    state             <= ST_ACK;
                end else timer <= timer - 1'b1;
                ST_REF_WAIT: if (timer == '0) state <= ST_ACK;
                             else timer <= timer - 1'b1;
                ST_RD_LAT: if (timer == '0) begin
                    oe_q    <= 1'b1;
                    dout_q  <= rd_word[DATA_WIDTH-1];
                    sh      <= rd_word << 1;
                    bit_cnt <= NW'(1);
                    state   <= ST_RD_SHIFT;
                end else timer <= timer - 1'b1;
                ST_RD_SHIFT: if (bit_cnt == NW'(DATA_WIDTH)) begin
                    oe_q   <= 1'b0;
                    dout_q <= 1'b0;
                    state  <= ST_ACK;
                end else begin
                    dout_q  <= sh[DATA_WIDTH-1];
                    sh      <= sh << 1;
                    bit_cnt <= bit_cnt + 1'b1;
                end
                ST_WR_SHIFT: begin
                    sh      <= wr_word;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (wr_commit) state <= ST_ACK;
                end
                ST_ACK: begin
                    ack_q   <= 1'b1;
                    err_out <= err_q;
                    state   <= ST_REL;
                end
                ST_REL: if (!bus.cmd_req) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cmd_ack        = ack_q;
    assign bus.cmd_err        = err_out;
    assign bus.dram_data_oe   = oe_q;
    assign bus.dram_data_out  = dout_q;
    assign bus.open_bank_mask = open_mask;
endmodule
